// File: rtl/pipelined_addsub.sv
// Purpose: parametrised add/subtract with the carry chain split into STAGES registered chunks, plus carry/borrow and signed overflow.
// Latency: STAGES cycles from accept to out_valid; one result per cycle.
// Backpressure: global stall, in_ready = !out_valid || out_ready; a stall freezes every stage register.
module pipelined_addsub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  // Bits handled per stage; guarded so a bad STAGES cannot divide by zero before the check fires.
  localparam int CW = (STAGES > 0) ? (WIDTH / STAGES) : 1;

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $fatal(1, "pipelined_addsub: WIDTH must be >= 1 and divisible by STAGES");
  end

  // Per-stage registers. Operands travel whole so later chunks and the sign bits
  // for overflow are still at hand; b is stored already inverted for subtraction.
  logic [STAGES-1:0] stage_vld;
  logic [STAGES-1:0] stage_c;
  logic [WIDTH-1:0]  stage_a  [STAGES];
  logic [WIDTH-1:0]  stage_bx [STAGES];
  logic [WIDTH-1:0]  stage_s  [STAGES];

  // What each stage sees at its input: stage 0 from the ports, stage k from stage k-1.
  logic [STAGES-1:0] src_vld;
  logic [STAGES-1:0] src_c;
  logic [WIDTH-1:0]  src_a    [STAGES];
  logic [WIDTH-1:0]  src_bx   [STAGES];
  logic [WIDTH-1:0]  src_s    [STAGES];
  logic [CW:0]       csum     [STAGES];
  logic [WIDTH-1:0]  merged_s [STAGES];

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Select stage inputs, add one chunk per stage and splice it into the partial sum.
  always_comb begin
    src_vld[0] = in_valid;
    src_a[0]   = a;
    src_bx[0]  = sub ? ~b : b;
    src_c[0]   = cin ^ sub;
    src_s[0]   = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = stage_vld[k-1];
      src_a[k]   = stage_a[k-1];
      src_bx[k]  = stage_bx[k-1];
      src_c[k]   = stage_c[k-1];
      src_s[k]   = stage_s[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      csum[k] = {1'b0, src_a[k][k*CW +: CW]} + {1'b0, src_bx[k][k*CW +: CW]}
              + {{CW{1'b0}}, src_c[k]};
      merged_s[k] = src_s[k];
      merged_s[k][k*CW +: CW] = csum[k][CW-1:0];
    end
  end

  // Advance the whole pipeline together; hold everything on a stall, clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_vld <= '0;
      stage_c   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stage_a[k]  <= '0;
        stage_bx[k] <= '0;
        stage_s[k]  <= '0;
      end
    end else if (advance) begin
      stage_vld <= src_vld;
      for (int k = 0; k < STAGES; k++) begin
        stage_c[k]  <= csum[k][CW];
        stage_a[k]  <= src_a[k];
        stage_bx[k] <= src_bx[k];
        stage_s[k]  <= merged_s[k];
      end
    end
  end

  // Outputs come straight from the last stage, so they are stable while stalled.
  assign out_valid = stage_vld[STAGES-1];
  assign s         = stage_s[STAGES-1];
  assign cout      = stage_c[STAGES-1];
  assign ovf       = (stage_a[STAGES-1][WIDTH-1] == stage_bx[STAGES-1][WIDTH-1])
                  && (stage_s[STAGES-1][WIDTH-1] != stage_a[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Purpose: self-checking bench for pipelined_addsub in three configurations (4/1, 8/2, 16/4).
// Latency: results are compared against an arithmetic reference model in acceptance order.
// Backpressure: random out_ready stalls; stalled outputs must keep showing the oldest expected result.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=4, STAGES=1
  logic       iv1, ir1, ci1, sb1, ov1, or1, co1, of1;
  logic [3:0] a1, b1, s1;
  // WIDTH=8, STAGES=2
  logic       iv2, ir2, ci2, sb2, ov2, or2, co2, of2;
  logic [7:0] a2, b2, s2;
  // WIDTH=16, STAGES=4
  logic        iv4, ir4, ci4, sb4, ov4, or4, co4, of4;
  logic [15:0] a4, b4, s4;

  pipelined_addsub #(.WIDTH(4), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(ci1), .sub(sb1),
    .out_valid(ov1), .out_ready(or1), .s(s1), .cout(co1), .ovf(of1));

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .cin(ci2), .sub(sb2),
    .out_valid(ov2), .out_ready(or2), .s(s2), .cout(co2), .ovf(of2));

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(ci4), .sub(sb4),
    .out_valid(ov4), .out_ready(or4), .s(s4), .cout(co4), .ovf(of4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: integer arithmetic on unsigned and signed interpretations.
  // Returns {ovf, cout, s[15:0]}.
  function automatic logic [17:0] model(input int w, input longint ua, input longint ub,
                                        input longint uc, input longint usub);
    longint m    = longint'(1) << w;
    longint half = m / 2;
    longint sa   = (ua >= half) ? ua - m : ua;
    longint sbv  = (ub >= half) ? ub - m : ub;
    longint r;
    longint sr;
    logic   co;
    logic   ov;
    if (usub == 0) begin
      r  = ua + ub + uc;
      co = (r >= m);
      sr = sa + sbv + uc;
    end else begin
      r  = ua - ub - uc;
      co = (ua >= ub + uc);
      sr = sa - sbv - uc;
    end
    r  = ((r % m) + m) % m;
    ov = (sr < -half) || (sr >= half);
    return {ov, co, 16'(r)};
  endfunction

  // Three-item stream 1+1, 2+2, 3+3 into the 8/2 unit; out_ready goes high at cycle release_at.
  task automatic run_stream(input int release_at, input string tag);
    int sent  = 0;
    int got   = 0;
    int first = -1;
    int last  = -1;
    for (int e = 0; e < 20; e++) begin
      iv2 = (sent < 3);
      a2  = 8'(sent + 1);
      b2  = 8'(sent + 1);
      ci2 = 1'b0;
      sb2 = 1'b0;
      or2 = (e >= release_at);
      #1;
      if (release_at == 0) chk({tag, "_in_ready"}, 32'(ir2), 1);
      if (ov2 && !or2) begin
        chk({tag, "_held_s"}, 32'(s2), 32'h02);
        chk({tag, "_stall_in_ready"}, 32'(ir2), 0);
      end
      if (ov2 && or2) begin
        if (got < 3) chk({tag, "_s"}, 32'(s2), 2 * (got + 1));
        else         chk({tag, "_extra_out"}, 32'(ov2), 0);
        got++;
        if (first < 0) first = e;
        last = e;
      end
      if (iv2 && ir2) sent++;
      step();
    end
    chk({tag, "_count_out"}, got, 3);
    chk({tag, "_count_in"}, sent, 3);
    if (release_at == 0) begin
      chk({tag, "_first_cycle"}, first, 2);
      chk({tag, "_back_to_back"}, last - first, 2);
    end
  endtask

  initial begin
    logic [17:0] q[$];
    logic [17:0] exp;
    int acc;
    int outs;
    int cyc;
    int lat;

    {iv1, a1, b1, ci1, sb1} = '0; or1 = 1'b1;
    {iv2, a2, b2, ci2, sb2} = '0; or2 = 1'b1;
    {iv4, a4, b4, ci4, sb4} = '0; or4 = 1'b1;

    // Reset state, observed while rst is still asserted.
    rst = 1'b1;
    step();
    chk("rst_out_valid1", 32'(ov1), 0);
    chk("rst_out_valid2", 32'(ov2), 0);
    chk("rst_out_valid4", 32'(ov4), 0);
    chk("rst_in_ready4", 32'(ir4), 1);
    chk("rst_s4", 32'(s4), 0);
    chk("rst_cout4", 32'(co4), 0);
    chk("rst_ovf4", 32'(of4), 0);
    step();
    rst = 1'b0;
    step();

    // T1: 4-bit single stage, 9+8+1.
    a1 = 4'd9; b1 = 4'd8; ci1 = 1'b1; sb1 = 1'b0; iv1 = 1'b1;
    #1;
    chk("t1_in_ready", 32'(ir1), 1);
    step();
    iv1 = 1'b0;
    chk("t1_out_valid", 32'(ov1), 1);
    chk("t1_s", 32'(s1), 32'h2);
    chk("t1_cout", 32'(co1), 1);
    chk("t1_ovf", 32'(of1), 1);
    step();
    chk("t1_drained", 32'(ov1), 0);

    // T2a: 0x7F + 0x01, exactly two edges from accept to result.
    a2 = 8'h7F; b2 = 8'h01; ci2 = 1'b0; sb2 = 1'b0; iv2 = 1'b1;
    step();
    iv2 = 1'b0;
    chk("t2a_not_early", 32'(ov2), 0);
    step();
    chk("t2a_out_valid", 32'(ov2), 1);
    chk("t2a_s", 32'(s2), 32'h80);
    chk("t2a_cout", 32'(co2), 0);
    chk("t2a_ovf", 32'(of2), 1);
    step();

    // T2b: 0 - 1.
    a2 = 8'h00; b2 = 8'h01; ci2 = 1'b0; sb2 = 1'b1; iv2 = 1'b1;
    step();
    iv2 = 1'b0;
    step();
    chk("t2b_out_valid", 32'(ov2), 1);
    chk("t2b_s", 32'(s2), 32'hFF);
    chk("t2b_cout", 32'(co2), 0);
    chk("t2b_ovf", 32'(of2), 0);
    step();

    // T2c: all-ones + 1 wraps.
    a2 = 8'hFF; b2 = 8'h01; ci2 = 1'b0; sb2 = 1'b0; iv2 = 1'b1;
    step();
    iv2 = 1'b0;
    step();
    chk("t2c_s", 32'(s2), 32'h00);
    chk("t2c_cout", 32'(co2), 1);
    chk("t2c_ovf", 32'(of2), 0);
    step();
    step();

    // T3: free-flowing stream; T4: same stream stalled for a few cycles.
    run_stream(0, "t3");
    run_stream(6, "t4");

    // T5: random traffic with random stalls on the 16/4 unit.
    acc = 0; outs = 0; cyc = 0;
    while ((acc < 1000 || q.size() > 0) && cyc < 20000) begin
      iv4 = (acc < 1000) && ($urandom_range(0, 9) < 7);
      a4  = 16'($urandom);
      b4  = 16'($urandom);
      ci4 = 1'($urandom);
      sb4 = 1'($urandom);
      or4 = (acc >= 1000) || ($urandom_range(0, 9) < 7);
      #1;
      chk("t5_in_ready", 32'(ir4), 32'(!ov4 || or4));
      if (ov4) begin
        if (q.size() == 0) begin
          chk("t5_spurious_out", 32'(ov4), 0);
        end else begin
          exp = q[0];
          chk("t5_s", 32'(s4), 32'(exp[15:0]));
          chk("t5_cout", 32'(co4), 32'(exp[16]));
          chk("t5_ovf", 32'(of4), 32'(exp[17]));
          if (or4) begin
            void'(q.pop_front());
            outs++;
          end
        end
      end
      if (iv4 && ir4) begin
        q.push_back(model(16, longint'(a4), longint'(b4), longint'(ci4), longint'(sb4)));
        acc++;
      end
      step();
      cyc++;
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    chk("t5_accepted", acc, 1000);
    chk("t5_count_out", outs, 1000);
    chk("t5_pending", q.size(), 0);

    // T6: fill the 16/4 pipeline, reset mid-stream, then confirm a clean restart.
    for (int i = 0; i < 3; i++) begin
      iv4 = 1'b1; a4 = 16'(i + 1); b4 = 16'h0100; ci4 = 1'b0; sb4 = 1'b0;
      step();
    end
    rst = 1'b1;
    a4  = 16'h5555;
    step();
    rst = 1'b0;
    iv4 = 1'b0;
    chk("t6_out_valid_after_rst", 32'(ov4), 0);
    chk("t6_s_after_rst", 32'(s4), 0);
    chk("t6_in_ready_after_rst", 32'(ir4), 1);
    for (int i = 0; i < 8; i++) begin
      chk("t6_no_stale_out", 32'(ov4), 0);
      step();
    end
    a4 = 16'h1234; b4 = 16'h0F0F; ci4 = 1'b1; sb4 = 1'b1; iv4 = 1'b1;
    exp = model(16, longint'(a4), longint'(b4), longint'(ci4), longint'(sb4));
    step();
    iv4 = 1'b0;
    lat = 1;
    while (!ov4 && lat < 20) begin
      step();
      lat++;
    end
    chk("t6_latency", lat, 4);
    chk("t6_s", 32'(s4), 32'(exp[15:0]));
    chk("t6_cout", 32'(co4), 32'(exp[16]));
    chk("t6_ovf", 32'(of4), 32'(exp[17]));
    step();
    chk("t6_single_out", 32'(ov4), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
